// File: rtl/ctrl_pkg.sv
// Shared constants for the pipelined control unit: opcode/funct codes, ALU op and
// regdst encodings, control-bundle field offsets and the all-zero bubble.
package ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_XORI  = 6'h0e;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_XOR = 6'h26;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2a;
    localparam logic [5:0] FN_SGT = 6'h2c;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_NOR = 4'd4,
        ALU_XOR = 4'd5,
        ALU_SLT = 4'd6,
        ALU_SLL = 4'd7,
        ALU_SRL = 4'd8,
        ALU_SGT = 4'd9
    } aluop_e;

    typedef enum logic [1:0] {
        RD_RT = 2'b00,
        RD_RD = 2'b01,
        RD_RA = 2'b10
    } regdst_e;

    // Fixed low fields; aluop width is a module parameter, so the fields above it
    // are located through the helper functions below.
    localparam int OFF_JAL      = 0;
    localparam int OFF_JR       = 1;
    localparam int OFF_ALUSRC   = 2;
    localparam int OFF_REGWRITE = 3;
    localparam int OFF_MEMWRITE = 4;
    localparam int OFF_MEMTOREG = 5;
    localparam int OFF_MEMREAD  = 6;
    localparam int OFF_ZERO_S   = 7;
    localparam int OFF_BRANCH   = 8;
    localparam int OFF_REGDST   = 9;
    localparam int OFF_ALUOP    = 11;

    function automatic int off_dest(int aluop_w);
        return OFF_ALUOP + aluop_w;
    endfunction

    function automatic int off_illegal(int aluop_w);
        return OFF_ALUOP + aluop_w + 5;
    endfunction

    function automatic int ctrl_cw(int aluop_w);
        return OFF_ALUOP + aluop_w + 6;
    endfunction

    localparam int ALUOP_W_DEFAULT = 4;
    localparam int CW_DEFAULT      = ctrl_cw(ALUOP_W_DEFAULT);
    localparam int ALUOP_W_MAX     = 16;
    localparam int CW_MAX          = ctrl_cw(ALUOP_W_MAX);

    localparam logic [CW_MAX-1:0] BUBBLE = '0;

    function automatic logic [15:0] sat_inc16(logic [15:0] value, logic en);
        return (en && (value != 16'hFFFF)) ? value + 16'd1 : value;
    endfunction

endpackage

// File: rtl/ctrl_decode_comb.sv
// Purely combinational opcode/funct decode into the control bundle, including the
// destination-register selection. Instruction-valid masking is left to the caller.
module ctrl_decode_comb
    import ctrl_pkg::*;
#(
    parameter int  ALUOP_W = 4,
    localparam int CW      = ctrl_cw(ALUOP_W)
) (
    input  logic [5:0]    opcode,
    input  logic [5:0]    funct,
    input  logic [4:0]    rt,
    input  logic [4:0]    rd,
    output logic [CW-1:0] ctrl
);

    aluop_e     aluop;
    regdst_e    regdst;
    logic       illegal;
    logic       branch;
    logic       zero_s;
    logic       memread;
    logic       memtoreg;
    logic       memwrite;
    logic       regwrite;
    logic       alusrc;
    logic       jr;
    logic       jal;
    logic [4:0] dest;

    // Unrecognised encodings collapse to a bubble that only carries the illegal flag.
    always_comb begin
        aluop    = ALU_ADD;
        regdst   = RD_RT;
        illegal  = 1'b0;
        branch   = 1'b0;
        zero_s   = 1'b0;
        memread  = 1'b0;
        memtoreg = 1'b0;
        memwrite = 1'b0;
        regwrite = 1'b0;
        alusrc   = 1'b0;
        jr       = 1'b0;
        jal      = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                regdst   = RD_RD;
                regwrite = 1'b1;
                case (funct)
                    FN_ADD: aluop = ALU_ADD;
                    FN_SUB: aluop = ALU_SUB;
                    FN_AND: aluop = ALU_AND;
                    FN_OR:  aluop = ALU_OR;
                    FN_NOR: aluop = ALU_NOR;
                    FN_XOR: aluop = ALU_XOR;
                    FN_SLT: aluop = ALU_SLT;
                    FN_SGT: aluop = ALU_SGT;
                    FN_SLL: begin
                        aluop  = ALU_SLL;
                        alusrc = 1'b1;
                    end
                    FN_SRL: begin
                        aluop  = ALU_SRL;
                        alusrc = 1'b1;
                    end
                    FN_JR: begin
                        regdst   = RD_RT;
                        regwrite = 1'b0;
                        jr       = 1'b1;
                    end
                    default: begin
                        regdst   = RD_RT;
                        regwrite = 1'b0;
                        illegal  = 1'b1;
                    end
                endcase
            end
            OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI: begin
                alusrc   = 1'b1;
                regwrite = 1'b1;
                case (opcode)
                    OP_ANDI: aluop = ALU_AND;
                    OP_ORI:  aluop = ALU_OR;
                    OP_XORI: aluop = ALU_XOR;
                    OP_SLTI: aluop = ALU_SLT;
                    default: aluop = ALU_ADD;
                endcase
            end
            OP_LW: begin
                memread  = 1'b1;
                memtoreg = 1'b1;
                regwrite = 1'b1;
                alusrc   = 1'b1;
            end
            OP_SW: begin
                memwrite = 1'b1;
                alusrc   = 1'b1;
            end
            OP_BEQ: begin
                branch = 1'b1;
                zero_s = 1'b1;
            end
            OP_BNE: branch = 1'b1;
            OP_J: begin
            end
            OP_JAL: begin
                regdst   = RD_RA;
                regwrite = 1'b1;
                jal      = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

    always_comb begin
        dest = 5'd0;
        if (regwrite) begin
            case (regdst)
                RD_RD:   dest = rd;
                RD_RA:   dest = 5'd31;
                RD_RT:   dest = rt;
                default: dest = 5'd0;
            endcase
        end
    end

    assign ctrl = {illegal, dest, ALUOP_W'(aluop), regdst, branch, zero_s, memread,
                   memtoreg, memwrite, regwrite, alusrc, jr, jal};

endmodule

// File: rtl/ctrl_pipe_decoder.sv
// Pipelined control unit: decode, load-use stall detection, flush, and a chain of
// NSTAGES control registers. Define CTRL_PERF_EN to add saturating perf counters.
module ctrl_pipe_decoder
    import ctrl_pkg::*;
#(
    parameter int  ALUOP_W = 4,
    parameter int  NSTAGES = 3,
    localparam int CW      = ctrl_cw(ALUOP_W)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [5:0]            opcode,
    input  logic [5:0]            funct,
    input  logic [4:0]            rs,
    input  logic [4:0]            rt,
    input  logic [4:0]            rd,
    input  logic                  flush,
    output logic                  hz_stall,
    output logic [CW-1:0]         id_ctrl,
`ifdef CTRL_PERF_EN
    output logic [15:0]           stall_cnt,
    output logic [15:0]           flush_cnt,
    output logic [15:0]           illegal_cnt,
`endif
    output logic [NSTAGES*CW-1:0] ctrl_pipe
);

    localparam int OFF_DEST    = off_dest(ALUOP_W);
    localparam int OFF_ILLEGAL = off_illegal(ALUOP_W);

    logic [CW-1:0] decoded;
    logic [CW-1:0] stage_q [NSTAGES];
    logic [4:0]    s1_dest;

    ctrl_decode_comb #(.ALUOP_W(ALUOP_W)) u_decode (
        .opcode (opcode),
        .funct  (funct),
        .rt     (rt),
        .rd     (rd),
        .ctrl   (decoded)
    );

    assign id_ctrl = id_valid ? decoded : BUBBLE[CW-1:0];

    // rt is compared even for instructions that do not read it: a spare stall is harmless.
    assign s1_dest  = stage_q[0][OFF_DEST +: 5];
    assign hz_stall = id_valid && stage_q[0][OFF_MEMREAD] && (s1_dest != 5'd0) &&
                      ((s1_dest == rs) || (s1_dest == rt));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NSTAGES; k++) begin
                stage_q[k] <= '0;
            end
        end else begin
            stage_q[0] <= (flush || hz_stall) ? BUBBLE[CW-1:0] : id_ctrl;
            for (int k = 1; k < NSTAGES; k++) begin
                stage_q[k] <= stage_q[k-1];
            end
        end
    end

    for (genvar g = 0; g < NSTAGES; g++) begin : g_flat
        assign ctrl_pipe[g*CW +: CW] = stage_q[g];
    end

`ifdef CTRL_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt   <= '0;
            flush_cnt   <= '0;
            illegal_cnt <= '0;
        end else begin
            stall_cnt   <= sat_inc16(stall_cnt, hz_stall);
            flush_cnt   <= sat_inc16(flush_cnt, flush);
            illegal_cnt <= sat_inc16(illegal_cnt, id_ctrl[OFF_ILLEGAL]);
        end
    end
`endif

endmodule

// File: tb/tb_ctrl_pipe_decoder.sv
// Self-checking bench for ctrl_pipe_decoder against a field-level reference model.
// Counter checks run only when CTRL_PERF_EN is defined.
module tb_ctrl_pipe_decoder;

    typedef struct packed {
        logic       illegal;
        logic [4:0] dest;
        logic [3:0] aluop;
        logic [1:0] regdst;
        logic       branch;
        logic       zero_s;
        logic       memread;
        logic       memtoreg;
        logic       memwrite;
        logic       regwrite;
        logic       alusrc;
        logic       jr;
        logic       jal;
    } ctrl_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        id_valid = 1'b0;
    logic [5:0]  opcode = '0;
    logic [5:0]  funct = '0;
    logic [4:0]  rs = '0;
    logic [4:0]  rt = '0;
    logic [4:0]  rd = '0;
    logic        flush = 1'b0;
    logic        hz_stall;
    logic [20:0] id_ctrl;
    logic [62:0] ctrl_pipe;
`ifdef CTRL_PERF_EN
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;
    logic [15:0] illegal_cnt;
`endif

    int checks = 0;
    int errors = 0;

    ctrl_t m [3];

    localparam logic [11:0] ITAB [25] = '{
        {6'h00, 6'h20}, {6'h00, 6'h22}, {6'h00, 6'h24}, {6'h00, 6'h25}, {6'h00, 6'h27},
        {6'h00, 6'h26}, {6'h00, 6'h2a}, {6'h00, 6'h00}, {6'h00, 6'h02}, {6'h00, 6'h2c},
        {6'h00, 6'h08}, {6'h00, 6'h3f}, {6'h08, 6'h00}, {6'h0c, 6'h00}, {6'h0d, 6'h00},
        {6'h0e, 6'h00}, {6'h0a, 6'h00}, {6'h23, 6'h00}, {6'h2b, 6'h00}, {6'h04, 6'h00},
        {6'h05, 6'h00}, {6'h02, 6'h00}, {6'h03, 6'h00}, {6'h3f, 6'h00}, {6'h10, 6'h00}
    };

    ctrl_pipe_decoder #(.ALUOP_W(4), .NSTAGES(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .id_valid    (id_valid),
        .opcode      (opcode),
        .funct       (funct),
        .rs          (rs),
        .rt          (rt),
        .rd          (rd),
        .flush       (flush),
        .hz_stall    (hz_stall),
        .id_ctrl     (id_ctrl),
`ifdef CTRL_PERF_EN
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt),
        .illegal_cnt (illegal_cnt),
`endif
        .ctrl_pipe   (ctrl_pipe)
    );

    always #5 clk = ~clk;

    // Reference decode written straight from the instruction table.
    function automatic ctrl_t model_decode(logic v, logic [5:0] op, logic [5:0] fn,
                                           logic [4:0] t, logic [4:0] d);
        ctrl_t c;
        c = '0;
        if (!v) return c;
        case (op)
            6'h00: begin
                c.regdst = 2'b01;
                c.regwrite = 1'b1;
                case (fn)
                    6'h20: c.aluop = 4'd0;
                    6'h22: c.aluop = 4'd1;
                    6'h24: c.aluop = 4'd2;
                    6'h25: c.aluop = 4'd3;
                    6'h27: c.aluop = 4'd4;
                    6'h26: c.aluop = 4'd5;
                    6'h2a: c.aluop = 4'd6;
                    6'h00: begin c.aluop = 4'd7; c.alusrc = 1'b1; end
                    6'h02: begin c.aluop = 4'd8; c.alusrc = 1'b1; end
                    6'h2c: c.aluop = 4'd9;
                    6'h08: begin c.regdst = 2'b00; c.regwrite = 1'b0; c.jr = 1'b1; end
                    default: begin c = '0; c.illegal = 1'b1; end
                endcase
            end
            6'h08: begin c.aluop = 4'd0; c.alusrc = 1'b1; c.regwrite = 1'b1; end
            6'h0c: begin c.aluop = 4'd2; c.alusrc = 1'b1; c.regwrite = 1'b1; end
            6'h0d: begin c.aluop = 4'd3; c.alusrc = 1'b1; c.regwrite = 1'b1; end
            6'h0e: begin c.aluop = 4'd5; c.alusrc = 1'b1; c.regwrite = 1'b1; end
            6'h0a: begin c.aluop = 4'd6; c.alusrc = 1'b1; c.regwrite = 1'b1; end
            6'h23: begin c.memread = 1'b1; c.memtoreg = 1'b1; c.regwrite = 1'b1; c.alusrc = 1'b1; end
            6'h2b: begin c.memwrite = 1'b1; c.alusrc = 1'b1; end
            6'h04: begin c.branch = 1'b1; c.zero_s = 1'b1; end
            6'h05: c.branch = 1'b1;
            6'h02: c = '0;
            6'h03: begin c.regdst = 2'b10; c.regwrite = 1'b1; c.jal = 1'b1; end
            default: c.illegal = 1'b1;
        endcase
        if (c.regwrite) c.dest = (c.regdst == 2'b01) ? d : (c.regdst == 2'b10) ? 5'd31 : t;
        return c;
    endfunction

    function automatic logic model_stall();
        return id_valid && m[0].memread && (m[0].dest != 5'd0) &&
               ((m[0].dest == rs) || (m[0].dest == rt));
    endfunction

    task automatic drive(input logic v, input logic [5:0] op, input logic [5:0] fn,
                         input logic [4:0] s, input logic [4:0] t, input logic [4:0] d,
                         input logic fl);
        id_valid = v; opcode = op; funct = fn; rs = s; rt = t; rd = d; flush = fl;
        #1;
    endtask

    // One clock edge, with the model advanced from the inputs present before it.
    task automatic tick();
        ctrl_t nxt;
        logic  st;
        st  = model_stall();
        nxt = model_decode(id_valid, opcode, funct, rt, rd);
        @(posedge clk);
        #1;
        m[2] = m[1];
        m[1] = m[0];
        m[0] = (st || flush) ? '0 : nxt;
    endtask

    task automatic reset_dut();
        drive(1'b0, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) m[i] = '0;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (ctrl_pipe !== 63'd0 || hz_stall !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_init pipe=%h stall=%b expected 0/0", ctrl_pipe, hz_stall);
        end
        reset_dut();
        drive(1'b1, 6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 1'b0);
        tick();
        drive(1'b1, 6'h23, 6'h00, 5'd1, 5'd5, 5'd0, 1'b0);
        tick();
        drive(1'b1, 6'h00, 6'h20, 5'd5, 5'd2, 5'd6, 1'b0);
        checks++;
        if (hz_stall !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_pre_stall got %b expected 1", hz_stall);
        end
        #1 rst = 1'b0;
        #1;
        checks++;
        if (ctrl_pipe !== 63'd0 || hz_stall !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_async pipe=%h stall=%b expected 0/0", ctrl_pipe, hz_stall);
        end
        reset_dut();
    endtask

    task automatic test_add();
        ctrl_t e;
        e = '0;
        e.dest = 5'd3; e.regdst = 2'b01; e.regwrite = 1'b1; e.aluop = 4'd0;
        drive(1'b1, 6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 1'b0);
        tick();
        checks++;
        if (ctrl_pipe[20:0] !== e) begin
            errors++;
            $display("[TB] FAIL add_stage1 got %h expected %h", ctrl_pipe[20:0], e);
        end
        drive(1'b0, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0);
        tick();
        tick();
        checks++;
        if (ctrl_pipe[62:42] !== e) begin
            errors++;
            $display("[TB] FAIL add_stage3 got %h expected %h", ctrl_pipe[62:42], e);
        end
    endtask

    task automatic test_load_use();
        ctrl_t lw_e;
        ctrl_t add_e;
        lw_e = model_decode(1'b1, 6'h23, 6'h00, 5'd5, 5'd0);
        add_e = model_decode(1'b1, 6'h00, 6'h20, 5'd2, 5'd6);
        drive(1'b1, 6'h23, 6'h00, 5'd1, 5'd5, 5'd0, 1'b0);
        tick();
        drive(1'b1, 6'h00, 6'h20, 5'd5, 5'd2, 5'd6, 1'b0);
        checks++;
        if (hz_stall !== 1'b1) begin
            errors++;
            $display("[TB] FAIL lu_stall_on got %b expected 1", hz_stall);
        end
        tick();
        checks++;
        if (ctrl_pipe[20:0] !== 21'd0 || ctrl_pipe[41:21] !== lw_e) begin
            errors++;
            $display("[TB] FAIL lu_bubble got %h expected %h", ctrl_pipe[41:0], {lw_e, 21'd0});
        end
        checks++;
        if (hz_stall !== 1'b0) begin
            errors++;
            $display("[TB] FAIL lu_stall_once got %b expected 0", hz_stall);
        end
        tick();
        checks++;
        if (ctrl_pipe[20:0] !== add_e) begin
            errors++;
            $display("[TB] FAIL lu_held_add got %h expected %h", ctrl_pipe[20:0], add_e);
        end
        drive(1'b1, 6'h23, 6'h00, 5'd1, 5'd0, 5'd0, 1'b0);
        tick();
        drive(1'b1, 6'h00, 6'h20, 5'd0, 5'd0, 5'd7, 1'b0);
        checks++;
        if (hz_stall !== 1'b0) begin
            errors++;
            $display("[TB] FAIL lu_zero_dest got %b expected 0", hz_stall);
        end
        tick();
    endtask

    task automatic test_flush();
        drive(1'b1, 6'h2b, 6'h00, 5'd1, 5'd2, 5'd0, 1'b1);
        tick();
        checks++;
        if (ctrl_pipe[20:0] !== 21'd0) begin
            errors++;
            $display("[TB] FAIL flush_stage1 got %h expected 0", ctrl_pipe[20:0]);
        end
        drive(1'b0, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0);
        tick();
        checks++;
        if (ctrl_pipe[21+4] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flush_stage2_memwrite got %b expected 0", ctrl_pipe[25]);
        end
        tick();
    endtask

    task automatic test_jal_illegal();
        ctrl_t e;
        e = '0;
        e.dest = 5'd31; e.regdst = 2'b10; e.regwrite = 1'b1; e.jal = 1'b1;
        drive(1'b1, 6'h03, 6'h00, 5'd4, 5'd7, 5'd9, 1'b0);
        checks++;
        if (id_ctrl !== e) begin
            errors++;
            $display("[TB] FAIL jal_decode got %h expected %h", id_ctrl, e);
        end
        tick();
        e = '0;
        e.illegal = 1'b1;
        drive(1'b1, 6'h3f, 6'h00, 5'd4, 5'd7, 5'd9, 1'b0);
        checks++;
        if (id_ctrl !== e) begin
            errors++;
            $display("[TB] FAIL illegal_decode got %h expected %h", id_ctrl, e);
        end
        tick();
        checks++;
        if (ctrl_pipe[20:0] !== e) begin
            errors++;
            $display("[TB] FAIL illegal_stage1 got %h expected %h", ctrl_pipe[20:0], e);
        end
        drive(1'b0, 6'h3f, 6'h00, 5'd4, 5'd7, 5'd9, 1'b0);
        checks++;
        if (id_ctrl !== 21'd0) begin
            errors++;
            $display("[TB] FAIL invalid_bubble got %h expected 0", id_ctrl);
        end
        tick();
    endtask

    task automatic test_random();
        logic [11:0] ent;
        logic [5:0]  op;
        logic [5:0]  fn;
        ctrl_t       exp_id;
        logic        exp_st;
        for (int i = 0; i < 400; i++) begin
            ent = ITAB[$urandom_range(0, 24)];
            op  = ent[11:6];
            fn  = (op == 6'h00) ? ent[5:0] : 6'($urandom);
            if ($urandom_range(0, 9) == 0) begin
                op = 6'($urandom);
                fn = 6'($urandom);
            end
            drive($urandom_range(0, 9) != 0, op, fn, 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
                  $urandom_range(0, 9) == 0);
            exp_id = model_decode(id_valid, opcode, funct, rt, rd);
            exp_st = model_stall();
            checks++;
            if (id_ctrl !== exp_id) begin
                errors++;
                $display("[TB] FAIL rand_id_ctrl op=%h fn=%h got %h expected %h", op, fn, id_ctrl, exp_id);
            end
            checks++;
            if (hz_stall !== exp_st) begin
                errors++;
                $display("[TB] FAIL rand_stall i=%0d got %b expected %b", i, hz_stall, exp_st);
            end
            tick();
            checks++;
            if (ctrl_pipe !== {m[2], m[1], m[0]}) begin
                errors++;
                $display("[TB] FAIL rand_pipe i=%0d got %h expected %h", i, ctrl_pipe, {m[2], m[1], m[0]});
            end
        end
    endtask

`ifdef CTRL_PERF_EN
    task automatic test_perf();
        reset_dut();
        checks++;
        if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0 || illegal_cnt !== 16'd0) begin
            errors++;
            $display("[TB] FAIL perf_reset got %0d/%0d/%0d expected 0/0/0", stall_cnt, flush_cnt, illegal_cnt);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 6'h23, 6'h00, 5'd1, 5'd5, 5'd0, 1'b0);
            tick();
            drive(1'b1, 6'h00, 6'h20, 5'd5, 5'd2, 5'd6, 1'b0);
            tick();
            tick();
        end
        drive(1'b1, 6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 1'b1);
        tick();
        tick();
        drive(1'b1, 6'h3f, 6'h00, 5'd1, 5'd2, 5'd3, 1'b0);
        tick();
        drive(1'b0, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0);
        tick();
        checks++;
        if (stall_cnt !== 16'd3 || flush_cnt !== 16'd2 || illegal_cnt !== 16'd1) begin
            errors++;
            $display("[TB] FAIL perf_counts got %0d/%0d/%0d expected 3/2/1", stall_cnt, flush_cnt, illegal_cnt);
        end
        force dut.hz_stall = 1'b1;
        repeat (65600) @(posedge clk);
        #1;
        release dut.hz_stall;
        checks++;
        if (stall_cnt !== 16'hFFFF || flush_cnt !== 16'd2) begin
            errors++;
            $display("[TB] FAIL perf_saturate got %h/%0d expected ffff/2", stall_cnt, flush_cnt);
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < 3; i++) m[i] = '0;
        $display("[TB] start");
        test_reset();
        test_add();
        test_load_use();
        test_flush();
        test_jal_illegal();
        test_random();
`ifdef CTRL_PERF_EN
        test_perf();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
